// File: rtl/dma_copy.sv
// dma_copy: bus-initiator that copies a block of 32-bit words between virtual addresses,
// one READ then one WRITE per word. Optional constant-fill mode under `DMA_FILL_EN`.
module dma_copy #(
  parameter int WORDS_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [15:0]        src,
  input  logic [15:0]        dst,
  input  logic [WORDS_W-1:0] len,
  input  logic               abort,
`ifdef DMA_FILL_EN
  input  logic               fill_mode,
  input  logic [31:0]        fill_value,
`endif
  output logic               bus_req,
  input  logic               bus_gnt,
  output logic [15:0]        address_virtual,
  output logic               WE,
  output logic [31:0]        writeData,
  input  logic [31:0]        readData,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_READ  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [WORDS_W-1:0] ONE_W = WORDS_W'(1);

  state_e              state_q, state_d;
  logic [15:0]         src_q, src_d;
  logic [15:0]         dst_q, dst_d;
  logic [WORDS_W-1:0]  count_q, count_d;
  logic [31:0]         data_q, data_d;
  logic                err_q, err_d;

  logic                bus_req_q, bus_req_d;
  logic                we_q, we_d;
  logic [15:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                fill_in_s;
  logic                fill_on_s;
  logic [31:0]         fill_val_s;
  logic                misalign_s;
  logic                last_s;
  logic                wrap_s;

`ifdef DMA_FILL_EN
  logic                fill_on_q, fill_on_d;
  logic [31:0]         fill_val_q, fill_val_d;

  assign fill_in_s  = fill_mode;
  assign fill_on_s  = fill_on_q;
  assign fill_val_s = fill_val_q;

  always_comb begin
    fill_on_d  = fill_on_q;
    fill_val_d = fill_val_q;
    if (state_q == S_IDLE && start) begin
      fill_on_d  = fill_mode;
      fill_val_d = fill_value;
    end else begin
      fill_on_d  = fill_on_q;
      fill_val_d = fill_val_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_on_q  <= 1'b0;
      fill_val_q <= 32'd0;
    end else begin
      fill_on_q  <= fill_on_d;
      fill_val_q <= fill_val_d;
    end
  end
`else
  assign fill_in_s  = 1'b0;
  assign fill_on_s  = 1'b0;
  assign fill_val_s = 32'd0;
`endif

  // Fill transfers never read, so the source pointer is neither alignment- nor wrap-checked.
  assign misalign_s = (dst[1:0] != 2'd0) || (!fill_in_s && (src[1:0] != 2'd0));
  assign last_s     = (count_q == ONE_W);
  assign wrap_s     = (dst_q == 16'hFFFC) || (!fill_on_s && (src_q == 16'hFFFC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!start)                 state_d = S_IDLE;
        else if (len == '0)         state_d = S_DONE;
        else if (misalign_s)        state_d = S_DONE;
        else                        state_d = S_REQ;
      end
      S_REQ: begin
        if (abort)                  state_d = S_DONE;
        else if (bus_gnt)           state_d = fill_on_s ? S_WRITE : S_READ;
        else                        state_d = S_REQ;
      end
      S_READ:                       state_d = S_WRITE;
      S_WRITE: begin
        if (last_s || abort)        state_d = S_DONE;
        else if (wrap_s)            state_d = S_DONE;
        else                        state_d = fill_on_s ? S_WRITE : S_READ;
      end
      S_DONE:                       state_d = S_IDLE;
      default:                      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    src_d   = src_q;
    dst_d   = dst_q;
    count_d = count_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = src;
          dst_d   = dst;
          count_d = len;
          err_d   = (len != '0) && misalign_s;
        end else begin
          err_d   = err_q;
        end
      end
      S_READ: begin
        data_d = readData;
      end
      S_WRITE: begin
        src_d   = src_q + 16'd4;
        dst_d   = dst_q + 16'd4;
        count_d = count_q - ONE_W;
        if (!(last_s || abort) && wrap_s) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
      end
      default: begin
        data_d = data_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q   <= 16'd0;
      dst_q   <= 16'd0;
      count_q <= '0;
      data_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      src_q   <= src_d;
      dst_q   <= dst_d;
      count_q <= count_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Outputs are decoded from the next state so the flopped values line up with the state they belong to.
  always_comb begin
    bus_req_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    we_d      = 1'b0;
    addr_d    = 16'd0;
    wdata_d   = 32'd0;
    case (state_d)
      S_REQ: begin
        bus_req_d = 1'b1;
        busy_d    = 1'b1;
      end
      S_READ: begin
        bus_req_d = 1'b1;
        busy_d    = 1'b1;
        addr_d    = src_d;
      end
      S_WRITE: begin
        bus_req_d = 1'b1;
        busy_d    = 1'b1;
        we_d      = 1'b1;
        addr_d    = dst_d;
        wdata_d   = fill_on_s ? fill_val_s : data_d;
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        bus_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_req_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 16'd0;
      wdata_q   <= 32'd0;
    end else begin
      bus_req_q <= bus_req_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign bus_req         = bus_req_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign err             = err_q;
  assign WE              = we_q;
  assign address_virtual = addr_q;
  assign writeData       = wdata_q;

endmodule

// File: tb/tb_dma_copy.sv
// Scoreboard bench for dma_copy: stimulus queues expected writes and done pulses,
// a negedge monitor pops and compares them against the memory port.
module tb_dma_copy;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] src, dst;
  logic [15:0] len;
  logic        abort;
  logic        bus_req, bus_gnt;
  logic [15:0] address_virtual;
  logic        WE;
  logic [31:0] writeData, readData;
  logic        busy, done, err;
`ifdef DMA_FILL_EN
  logic        fill_mode;
  logic [31:0] fill_value;
`endif

  dma_copy #(.WORDS_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src(src), .dst(dst), .len(len), .abort(abort),
`ifdef DMA_FILL_EN
    .fill_mode(fill_mode), .fill_value(fill_value),
`endif
    .bus_req(bus_req), .bus_gnt(bus_gnt), .address_virtual(address_virtual), .WE(WE),
    .writeData(writeData), .readData(readData), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Memory model
  logic [31:0] mem [0:16383];
  logic        pl_en;
  logic [15:0] pl_addr;
  logic [31:0] pl_data;

  always @(posedge clk) begin
    if (WE) mem[address_virtual[15:2]] <= writeData;
    else if (pl_en) mem[pl_addr[15:2]] <= pl_data;
  end
  assign readData = mem[address_virtual[15:2]];

  typedef struct { logic [15:0] addr; logic [31:0] data; } wr_t;
  typedef struct { int cyc; logic err; } dn_t;
  wr_t exp_wr[$];
  dn_t exp_dn[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic req_seen = 1'b0;
  logic rd_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT writes or signals done
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_req) req_seen = 1'b1;
      if (bus_req && !WE && address_virtual != 16'd0) rd_seen = 1'b1;
      if (bus_req && !bus_gnt)
        chk("no_access_without_gnt", {15'd0, WE, address_virtual}, 64'd0);
      if (WE) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", {address_virtual, writeData}, 64'd0);
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          chk("write_addr_data", {address_virtual, writeData}, {w.addr, w.data});
        end
      end
      if (done) begin
        if (exp_dn.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          dn_t d;
          d = exp_dn.pop_front();
          chk("done_err", {63'd0, err}, {63'd0, d.err});
          chk("done_busy_low", {63'd0, busy}, 64'd0);
          if (d.cyc >= 0) chk("done_cycle", 64'(cyc), 64'(d.cyc));
        end
      end
    end
  end

  task automatic preload(input logic [15:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic exp_write(input logic [15:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    exp_wr.push_back(w);
  endtask

  // Called at a negedge; lat < 0 means no done-cycle check, want_done = 0 means no done expected.
  task automatic launch(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                        input int lat, input logic e, input logic want_done);
    dn_t x;
    req_seen = 1'b0;
    rd_seen  = 1'b0;
    if (want_done) begin
      x.cyc = (lat < 0) ? -1 : cyc + lat;
      x.err = e;
      exp_dn.push_back(x);
    end
    start = 1'b1; src = s; dst = d; len = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && exp_dn.size() != 0; i++) @(negedge clk);
    if (exp_dn.size() != 0) begin
      chk("done_timeout", 64'(exp_dn.size()), 64'd0);
      exp_dn.delete();
    end
    @(negedge clk);
    chk("all_writes_seen", 64'(exp_wr.size()), 64'd0);
    exp_wr.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; src = 16'd0; dst = 16'd0; len = 16'd0; abort = 1'b0;
    bus_gnt = 1'b0; pl_en = 1'b0; pl_addr = 16'd0; pl_data = 32'd0;
`ifdef DMA_FILL_EN
    fill_mode = 1'b0; fill_value = 32'd0;
`endif
    // Reset with random inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'($urandom); src = 16'($urandom); dst = 16'($urandom);
      len = 16'($urandom); abort = 1'($urandom); bus_gnt = 1'($urandom);
      #1;
      chk("reset_outputs", {bus_req, WE, busy, done, err, address_virtual, writeData},
          64'd0);
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0; bus_gnt = 1'b1; src = 16'd0; dst = 16'd0; len = 16'd0;
    rst_n = 1'b1;

    preload(16'h0000, 32'h11111111);
    preload(16'h0004, 32'h22222222);
    preload(16'h0008, 32'h33333333);
    preload(16'h000C, 32'h44444444);
    preload(16'h0608, 32'h00000000);
    preload(16'h0700, 32'h00000000);
    preload(16'h0704, 32'h00000000);
    chk("idle_after_reset", {62'd0, req_seen, busy}, 64'd0);

    // Basic copy
    exp_write(16'h0100, 32'h11111111);
    exp_write(16'h0104, 32'h22222222);
    exp_write(16'h0108, 32'h33333333);
    exp_write(16'h010C, 32'h44444444);
    launch(16'h0000, 16'h0100, 16'd4, 10, 1'b0, 1'b1);
    wait_idle();
    chk("copy_mem0", 64'(mem[16'h0100 >> 2]), 64'h11111111);
    chk("copy_mem3", 64'(mem[16'h010C >> 2]), 64'h44444444);

    // Grant delayed 5 cycles
    bus_gnt = 1'b0;
    exp_write(16'h0400, 32'h11111111);
    exp_write(16'h0404, 32'h22222222);
    launch(16'h0000, 16'h0400, 16'd2, 11, 1'b0, 1'b1);
    chk("req_raised", {63'd0, bus_req}, 64'd1);
    repeat (5) @(negedge clk);
    bus_gnt = 1'b1;
    wait_idle();

    // Misaligned source
    launch(16'h0002, 16'h0500, 16'd2, -1, 1'b1, 1'b1);
    wait_idle();
    chk("misalign_no_req", {63'd0, req_seen}, 64'd0);
    chk("err_sticky", {63'd0, err}, 64'd1);

    // Destination wraps past 0xFFFC
    exp_write(16'hFFF8, 32'h11111111);
    exp_write(16'hFFFC, 32'h22222222);
    launch(16'h0000, 16'hFFF8, 16'd4, 6, 1'b1, 1'b1);
    wait_idle();

    // Zero length
    launch(16'h0000, 16'h0500, 16'd0, -1, 1'b0, 1'b1);
    wait_idle();
    chk("len0_no_req", {63'd0, req_seen}, 64'd0);

    // Abort in the WRITE of word 2 of 8
    exp_write(16'h0600, 32'h11111111);
    exp_write(16'h0604, 32'h22222222);
    launch(16'h0000, 16'h0600, 16'd8, 6, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_idle();
    chk("abort_mem2_untouched", 64'(mem[16'h0608 >> 2]), 64'd0);

    // Reset asserted mid-READ
    launch(16'h0000, 16'h0700, 16'd2, -1, 1'b0, 1'b0);
    @(negedge clk);
    chk("read_phase", {bus_req, WE, address_virtual}, {1'b1, 1'b0, 16'h0000});
    #2 rst_n = 1'b0;
    #1 chk("async_drop", {62'd0, bus_req, WE}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_dst0_untouched", 64'(mem[16'h0700 >> 2]), 64'd0);
    chk("reset_dst1_untouched", 64'(mem[16'h0704 >> 2]), 64'd0);

`ifdef DMA_FILL_EN
    // Fill mode
    fill_mode = 1'b1; fill_value = 32'hDEADBEEF;
    exp_write(16'h0200, 32'hDEADBEEF);
    exp_write(16'h0204, 32'hDEADBEEF);
    exp_write(16'h0208, 32'hDEADBEEF);
    launch(16'h0010, 16'h0200, 16'd3, 5, 1'b0, 1'b1);
    fill_mode = 1'b0; fill_value = 32'd0;
    wait_idle();
    chk("fill_no_read", {63'd0, rd_seen}, 64'd0);
    chk("fill_mem2", 64'(mem[16'h0208 >> 2]), 64'hDEADBEEF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
